// File: rtl/chr_rom_reader.sv
// CHR pattern-table reader: byte reads from 16-bit SRAM with a one-word cache,
// sharing the SRAM with the CHR loader until the load completes.
module chr_rom_reader #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_load_done,
  input  logic [19:0] i_ld_sram_addr,
  input  logic [15:0] i_ld_sram_wdata,
  input  logic        i_ld_sram_oe_n,
  input  logic        i_ld_sram_we_n,
  input  logic        i_ld_sram_ub_n,
  input  logic        i_ld_sram_lb_n,
  input  logic        i_ppu_req,
  input  logic [12:0] i_ppu_addr,
  input  logic [6:0]  i_chr_bank,
  output logic        o_ppu_ack,
  output logic [7:0]  o_ppu_rdata,
  output logic        o_busy,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  typedef enum logic [1:0] {WAIT_LOAD, IDLE, ACCESS, SAMPLE} state_t;

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_CYCLES - 1);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [19:0] word_addr;
  logic        upper;
  logic        ub_q, lb_q;
  logic        cache_vld;
  logic [19:0] cache_addr;
  logic [15:0] cache_data;

  logic [19:0] req_byte;
  logic [19:0] req_word;
  logic        hit;

  // Byte bit 3 picks the lane; the remaining bits fold into the word address.
  assign req_byte = {i_chr_bank, i_ppu_addr};
  assign req_word = {1'b0, req_byte[19:4], req_byte[2:0]};
  assign hit      = cache_vld && (cache_addr == req_word);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= WAIT_LOAD;
      wait_cnt    <= '0;
      word_addr   <= '0;
      upper       <= 1'b0;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      cache_vld   <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      o_ppu_ack   <= 1'b0;
      o_ppu_rdata <= '0;
    end else begin
      o_ppu_ack <= 1'b0;
      if (!i_load_done) begin
        // Loader reclaimed the SRAM: drop any in-flight access silently.
        state     <= WAIT_LOAD;
        cache_vld <= 1'b0;
        wait_cnt  <= '0;
        ub_q      <= 1'b1;
        lb_q      <= 1'b1;
      end else begin
        case (state)
          WAIT_LOAD: begin
            cache_vld <= 1'b0;
            state     <= IDLE;
          end
          IDLE: begin
            if (i_ppu_req && !o_ppu_ack) begin
              if (hit) begin
                o_ppu_rdata <= req_byte[3] ? cache_data[15:8] : cache_data[7:0];
                o_ppu_ack   <= 1'b1;
              end else begin
                word_addr <= req_word;
                upper     <= req_byte[3];
                ub_q      <= ~req_byte[3];
                lb_q      <= req_byte[3];
                wait_cnt  <= '0;
                state     <= ACCESS;
              end
            end
          end
          ACCESS: begin
            if (wait_cnt == LAST_WAIT) begin
              wait_cnt <= '0;
              state    <= SAMPLE;
            end else begin
              wait_cnt <= wait_cnt + 3'd1;
            end
          end
          SAMPLE: begin
            o_ppu_rdata <= upper ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
            o_ppu_ack   <= 1'b1;
            cache_data  <= i_sram_rdata;
            cache_addr  <= word_addr;
            cache_vld   <= 1'b1;
            ub_q        <= 1'b1;
            lb_q        <= 1'b1;
            state       <= IDLE;
          end
          default: state <= WAIT_LOAD;
        endcase
      end
    end
  end

  assign o_busy = (state != IDLE);

  // Ownership switches combinationally so the loader sees no turnaround delay.
  assign o_sram_addr  = i_load_done ? word_addr : i_ld_sram_addr;
  assign o_sram_wdata = i_load_done ? 16'h0000  : i_ld_sram_wdata;
  assign o_sram_oe_n  = i_load_done ? 1'b0      : i_ld_sram_oe_n;
  assign o_sram_we_n  = i_load_done ? 1'b1      : i_ld_sram_we_n;
  assign o_sram_ub_n  = i_load_done ? ub_q      : i_ld_sram_ub_n;
  assign o_sram_lb_n  = i_load_done ? lb_q      : i_ld_sram_lb_n;

endmodule

// File: doc/chr_rom_reader.md
CHR_ROM_READER -- requirements
Module: chr_rom_reader

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of SRAM access-time cycles (1..7) between address drive and data sample.
REQ-002 SHALL have ports:
- i_clk  in  1  PPU clock.
- i_rstn  in  1  Reset, asynchronous, active-low.
REQ-003 SHALL have CHR loader ports:
- i_load_done  in  1  CHR loader finished; SRAM owned by this block when 1.
- i_ld_sram_addr  in  20  Loader SRAM address.
- i_ld_sram_wdata  in  16  Loader SRAM write data.
- i_ld_sram_oe_n, i_ld_sram_we_n, i_ld_sram_ub_n, i_ld_sram_lb_n  in  1 each  Loader SRAM strobes.
REQ-004 SHALL have PPU ports:
- i_ppu_req  in  1  Level request, held until ack.
- i_ppu_addr  in  13  Pattern-table byte address 0x0000-0x1FFF.
- i_chr_bank  in  7  8 KB CHR bank select from mapper.
- o_ppu_ack  out  1  One-cycle pulse; read data valid.
- o_ppu_rdata  out  8  Read byte, held until next ack.
- o_busy  out  1  High when not in IDLE.
REQ-005 SHALL have SRAM ports:
- o_sram_addr  out  20  Word address.
- o_sram_wdata  out  16  Write data.
- i_sram_rdata  in  16  Read data.
- o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM strobes, active-low.

Function
REQ-006 SHALL combinationally pass all i_ld_sram_* to the SRAM outputs while i_load_done=0.
REQ-007 SHALL, while i_load_done=1, drive o_sram_we_n=1, o_sram_wdata=0, o_sram_oe_n=0, and the registered read address/lanes.
REQ-008 SHALL form linear byte address A[19:0]={i_chr_bank, i_ppu_addr}, latched at accept.
REQ-009 SHALL map A to SRAM word {1'b0, A[19:4], A[2:0]}, with A[3]=1 -> upper lane (ub_n=0, lb_n=1), A[3]=0 -> lower lane (ub_n=1, lb_n=0).
REQ-010 SHALL return i_sram_rdata[15:8] when A[3]=1, else [7:0].
REQ-011 SHALL implement FSM states WAIT_LOAD, IDLE, ACCESS, SAMPLE:
- WAIT_LOAD -> IDLE when i_load_done=1.
- IDLE -> ACCESS on i_ppu_req=1 and cache miss.
- ACCESS -> SAMPLE after WAIT_CYCLES cycles in ACCESS.
- SAMPLE -> IDLE unconditionally.
REQ-012 SHALL drive lanes from the latched address in ACCESS and SAMPLE, and ub_n=lb_n=1 with the address held in IDLE.
REQ-013 SHALL, in SAMPLE, register the selected byte into o_ppu_rdata, assert o_ppu_ack for exactly that one registered cycle, store the 16-bit word and its word address in a one-entry cache, and set cache valid.
REQ-014 SHALL, in IDLE with i_ppu_req=1 and a cache hit (valid, and cached word address equals the REQ-009 address), register the cached byte and pulse o_ppu_ack on the next cycle without an SRAM access; FSM stays IDLE.
REQ-015 Miss latency: accept edge N -> o_ppu_ack high after edge N+WAIT_CYCLES+1. Hit latency: ack high after edge N.
REQ-016 SHALL not accept a request in the cycle o_ppu_ack=1; the requester drops i_ppu_req on seeing ack.
REQ-017 SHALL ignore i_ppu_addr and i_chr_bank changes after accept until ack.
REQ-018 SHALL, when i_load_done falls in any state, go to WAIT_LOAD, clear cache valid, abandon any access without ack, and revert to loader pass-through.
REQ-019 SHALL clear cache valid whenever the FSM is in WAIT_LOAD.
REQ-020 SHALL hold o_busy=1 in WAIT_LOAD, ACCESS and SAMPLE.

Reset
REQ-021 SHALL, on i_rstn=0, asynchronously set: FSM=WAIT_LOAD, o_ppu_ack=0, o_ppu_rdata=0x00, cache valid=0, wait counter=0, latched address=0, internal lanes ub_n=lb_n=1.
REQ-022 SHALL, after reset, remain in WAIT_LOAD until i_load_done=1, regardless of i_ppu_req.

Verification
REQ-023 Pass-through: i_load_done=0, i_ld_sram_addr=0x12345, we_n=0 -> o_sram_addr=0x12345 and o_sram_we_n=0 in the same cycle; i_ppu_req=1 -> no ack.
REQ-024 Miss read: done=1, bank=0x01, addr=0x0008, SRAM word 0x01000 = 0xAB00 -> o_sram_addr=0x01000, ub_n=0, lb_n=1, rdata=0xAB, ack 3 cycles after accept (WAIT_CYCLES=2).
REQ-025 Hit: next request bank=0x01, addr=0x0000 (same word, lower lane) -> rdata=0x00 with ack 1 cycle after accept; o_sram_oe_n access count unchanged.
REQ-026 Top boundary: bank=0x7F, addr=0x1FFF -> o_sram_addr=0x7FFFF, upper lane selected.
REQ-027 Abort: i_load_done dropped while in ACCESS -> no ack, FSM=WAIT_LOAD, cache invalid, pass-through resumes; re-raise done and repeat the prior address -> full miss latency.
REQ-028 Async reset asserted mid-SAMPLE -> o_ppu_ack=0 and o_ppu_rdata=0x00 immediately, without a clock edge.
